// File: rtl/wiphase_spi_pkg.sv
// Shared WiPhase SPI definitions: register map, status/control bit indices, FSM states.
package wiphase_spi_pkg;

   localparam logic [2:0] ADDR_RXDATA  = 3'd0;
   localparam logic [2:0] ADDR_TXDATA  = 3'd1;
   localparam logic [2:0] ADDR_STATUS  = 3'd2;
   localparam logic [2:0] ADDR_CONTROL = 3'd3;
   localparam logic [2:0] ADDR_EOPVAL  = 3'd6;

   localparam int unsigned BIT_EOP  = 9;
   localparam int unsigned BIT_E    = 8;
   localparam int unsigned BIT_RRDY = 7;
   localparam int unsigned BIT_TRDY = 6;
   localparam int unsigned BIT_TMT  = 5;
   localparam int unsigned BIT_TOE  = 4;
   localparam int unsigned BIT_ROE  = 3;
   localparam int unsigned BIT_TUR  = 2;

   // Writable irq-enable positions in the control register.
   localparam logic [15:0] CTRL_MASK = 16'h03FC;

   typedef enum logic {ST_IDLE, ST_ACTIVE} spi_state_e;

endpackage

// File: rtl/wiphase_spi_slave_if.sv
// CPU register-port bundle of the WiPhase SPI slave (two-cycle Avalon-style access).
interface wiphase_spi_slave_if;
   logic        spi_select;
   logic [2:0]  mem_addr;
   logic        read_n;
   logic        write_n;
   logic [15:0] data_from_cpu;
   logic [15:0] data_to_cpu;
   logic        irq;
   logic        dataavailable;
   logic        readyfordata;
   logic        endofpacket;

   modport master (
      output spi_select, mem_addr, read_n, write_n, data_from_cpu,
      input  data_to_cpu, irq, dataavailable, readyfordata, endofpacket
   );

   modport slave (
      input  spi_select, mem_addr, read_n, write_n, data_from_cpu,
      output data_to_cpu, irq, dataavailable, readyfordata, endofpacket
   );
endinterface

// File: rtl/wiphase_spi_sync.sv
// N-flop synchronizer with registered-history rise/fall pulses.
module wiphase_spi_sync #(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              q_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chain <= {STAGES{RESET_VAL}};
         q_d   <= RESET_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], d};
         q_d   <= chain[STAGES-1];
      end
   end

   assign q    = chain[STAGES-1];
   assign rise = q & ~q_d;
   assign fall = ~q & q_d;

endmodule

// File: rtl/wiphase_spi_slave.sv
// WiPhase SPI slave, mode 0, MSB first, oversampled on clk.
// Optional end-of-packet register enabled by defining SPI_SLAVE_EOP_EN.
module wiphase_spi_slave
   import wiphase_spi_pkg::*;
#(
   parameter int unsigned DATABITS    = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   wiphase_spi_slave_if.slave  bus,
   input  logic                SCLK,
   input  logic                SS_n,
   input  logic                MOSI,
   output logic                MISO,
   output logic                MISO_oe
);

   localparam int unsigned BW = $clog2(DATABITS);

   logic sclk_lvl_unused, sclk_rise, sclk_fall;
   logic ss_s, ss_rise, ss_fall;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   // SS_n chain resets low so a select already asserted at reset release is not seen as a fall.
   wiphase_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .reset_n(reset_n), .d(SCLK),
      .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));
   wiphase_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ss (
      .clk(clk), .reset_n(reset_n), .d(SS_n),
      .q(ss_s), .rise(ss_rise), .fall(ss_fall));
   wiphase_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .reset_n(reset_n), .d(MOSI),
      .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

   spi_state_e state, state_nx;
   logic load_first, shift_en, fall_en, abort, oe;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (ss_fall) state_nx = ST_ACTIVE;
         ST_ACTIVE: if (ss_rise) state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      load_first = 1'b0;
      shift_en   = 1'b0;
      fall_en    = 1'b0;
      abort      = 1'b0;
      oe         = 1'b0;
      case (state)
         ST_IDLE:   load_first = ss_fall;
         ST_ACTIVE: begin
            abort    = ss_rise;
            shift_en = sclk_rise & ~ss_rise;
            fall_en  = sclk_fall & ~ss_rise;
            oe       = ~ss_s;
         end
         default: ;
      endcase
   end

   // CPU port: p1 strobes on the first select cycle, actions on the registered strobe.
   logic        sel_d, rd_p1, wr_p1, rd_q, wr_q;
   logic [2:0]  addr_q;
   logic [15:0] wdata_q, rdata_q, status, ctrl;
   logic        rd_rx, wr_tx, wr_status, wr_ctrl, irq_q;

   assign rd_p1     = bus.spi_select & ~sel_d & ~bus.read_n;
   assign wr_p1     = bus.spi_select & ~sel_d & ~bus.write_n;
   assign rd_rx     = rd_q & (addr_q == ADDR_RXDATA);
   assign wr_tx     = wr_q & (addr_q == ADDR_TXDATA);
   assign wr_status = wr_q & (addr_q == ADDR_STATUS);
   assign wr_ctrl   = wr_q & (addr_q == ADDR_CONTROL);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_d   <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         sel_d <= bus.spi_select;
         rd_q  <= rd_p1;
         wr_q  <= wr_p1;
         if (rd_p1 | wr_p1) begin
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.data_from_cpu;
         end
      end
   end

   logic [DATABITS-1:0] shift_reg, shift_nx, rx_holding, tx_holding, tx_word;
   logic [BW-1:0]       bitcnt;
   logic                reload_pend, primed, miso_q;
   logic                rrdy, roe, toe, tur, eop;
   logic                load, frame_done, toe_set;

   assign load       = load_first | (fall_en & reload_pend);
   assign tx_word    = primed ? tx_holding : '0;
   assign shift_nx   = {shift_reg[DATABITS-2:0], mosi_s};
   assign frame_done = shift_en & (bitcnt == BW'(DATABITS - 1));
   // A load in the same cycle frees the holding register, so the write is accepted.
   assign toe_set    = wr_tx & primed & ~load;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_reg   <= '0;
         bitcnt      <= '0;
         reload_pend <= 1'b0;
         miso_q      <= 1'b0;
         rx_holding  <= '0;
      end else begin
         if (load_first) bitcnt <= '0;
         if (load) begin
            shift_reg   <= tx_word;
            miso_q      <= tx_word[DATABITS-1];
            reload_pend <= 1'b0;
         end else if (fall_en) begin
            miso_q <= shift_reg[DATABITS-1];
         end
         if (shift_en) begin
            shift_reg <= shift_nx;
            bitcnt    <= frame_done ? '0 : bitcnt + BW'(1);
         end
         if (frame_done) begin
            rx_holding  <= shift_nx;
            reload_pend <= 1'b1;
         end
         if (abort) begin
            bitcnt      <= '0;
            reload_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_holding <= '0;
         primed     <= 1'b0;
         rrdy       <= 1'b0;
         roe        <= 1'b0;
         toe        <= 1'b0;
         tur        <= 1'b0;
         ctrl       <= '0;
      end else begin
         if (wr_tx & ~toe_set) begin
            tx_holding <= wdata_q[DATABITS-1:0];
            primed     <= 1'b1;
         end else if (load) begin
            primed <= 1'b0;
         end
         if (frame_done)  rrdy <= 1'b1;
         else if (rd_rx)  rrdy <= 1'b0;
         if (frame_done & rrdy & ~rd_rx) roe <= 1'b1;
         else if (wr_status)             roe <= 1'b0;
         if (toe_set)        toe <= 1'b1;
         else if (wr_status) toe <= 1'b0;
         if (load & ~primed) tur <= 1'b1;
         else if (wr_status) tur <= 1'b0;
         if (wr_ctrl) ctrl <= wdata_q & CTRL_MASK;
      end
   end

`ifdef SPI_SLAVE_EOP_EN
   logic [15:0] eop_val;
   logic        eop_set;

   assign eop_set = (rd_rx & (rdata_q == eop_val)) | (wr_tx & (wdata_q == eop_val));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         eop_val <= '0;
         eop     <= 1'b0;
      end else begin
         if (wr_q & (addr_q == ADDR_EOPVAL)) eop_val <= wdata_q;
         if (eop_set)        eop <= 1'b1;
         else if (wr_status) eop <= 1'b0;
      end
   end
`else
   assign eop = 1'b0;
`endif

   always_comb begin
      status           = '0;
      status[BIT_EOP]  = eop;
      status[BIT_E]    = roe | toe | tur;
      status[BIT_RRDY] = rrdy;
      status[BIT_TRDY] = ~primed;
      status[BIT_TMT]  = ~primed & (state == ST_IDLE);
      status[BIT_TOE]  = toe;
      status[BIT_ROE]  = roe;
      status[BIT_TUR]  = tur;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         irq_q <= |(status & ctrl);
         if (rd_p1) begin
            case (bus.mem_addr)
               ADDR_RXDATA:  rdata_q <= 16'(rx_holding);
               ADDR_STATUS:  rdata_q <= status;
               ADDR_CONTROL: rdata_q <= ctrl;
`ifdef SPI_SLAVE_EOP_EN
               ADDR_EOPVAL:  rdata_q <= eop_val;
`endif
               default:      rdata_q <= '0;
            endcase
         end
      end
   end

   assign bus.data_to_cpu   = rdata_q;
   assign bus.irq           = irq_q;
   assign bus.dataavailable = rrdy;
   assign bus.readyfordata  = ~primed;
   assign bus.endofpacket   = eop;
   assign MISO              = miso_q;
   assign MISO_oe           = oe;

endmodule

// File: tb/tb_wiphase_spi_slave.sv
// Directed bench for wiphase_spi_slave: mode-0 master model plus two-cycle CPU accesses.
module tb_wiphase_spi_slave;

   localparam int unsigned HALF = 250;

   logic clk = 1'b0;
   logic reset_n;
   logic SCLK, SS_n, MOSI, MISO, MISO_oe;
   int   checks = 0;
   int   failures = 0;

   wiphase_spi_slave_if bus ();

   wiphase_spi_slave #(.DATABITS(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cpu_write(input logic [2:0] addr, input logic [15:0] data);
      @(negedge clk);
      bus.spi_select = 1'b1; bus.write_n = 1'b0;
      bus.mem_addr = addr; bus.data_from_cpu = data;
      wait_clks(2);
      bus.spi_select = 1'b0; bus.write_n = 1'b1;
      wait_clks(1);
   endtask

   task automatic cpu_read(input logic [2:0] addr, output logic [15:0] data);
      @(negedge clk);
      bus.spi_select = 1'b1; bus.read_n = 1'b0; bus.mem_addr = addr;
      wait_clks(2);
      data = bus.data_to_cpu;
      bus.spi_select = 1'b0; bus.read_n = 1'b1;
      wait_clks(1);
   endtask

   // Mode-0 master: MISO sampled just before each SCLK rise, MOSI changed while SCLK is low.
   task automatic spi_frame(input logic [7:0] tx, input int unsigned nbits,
                            output logic [7:0] rx, output logic oe);
      logic [7:0] sh;
      sh = tx; rx = '0; oe = 1'b0;
      @(negedge clk);
      SS_n = 1'b0;
      for (int unsigned i = 0; i < nbits; i++) begin
         MOSI = sh[7];
         sh = {sh[6:0], 1'b0};
         wait_clks(HALF);
         rx = {rx[6:0], MISO};
         if (i == 0) oe = MISO_oe;
         SCLK = 1'b1;
         wait_clks(HALF);
         SCLK = 1'b0;
      end
      wait_clks(HALF);
      SS_n = 1'b1;
      wait_clks(HALF + 10);
   endtask

   logic [15:0] rd;
   logic [7:0]  mb;
   logic        oe;

   initial begin
      reset_n = 1'b0; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
      bus.spi_select = 1'b0; bus.read_n = 1'b1; bus.write_n = 1'b1;
      bus.mem_addr = '0; bus.data_from_cpu = '0;
      wait_clks(5);
      reset_n = 1'b1;
      wait_clks(10);

      check("rst_data_to_cpu", bus.data_to_cpu, 16'h0000);
      check("rst_irq", 16'(bus.irq), 16'h0);
      check("rst_miso", 16'(MISO), 16'h0);
      check("rst_miso_oe", 16'(MISO_oe), 16'h0);
      check("rst_rrdy", 16'(bus.dataavailable), 16'h0);
      check("rst_trdy", 16'(bus.readyfordata), 16'h1);
      check("rst_eop", 16'(bus.endofpacket), 16'h0);
      cpu_read(3'd2, rd); check("rst_status", rd, 16'h0060);

      // Basic frame: tx 0xA5, rx 0x3C; trailing SCLK fall reloads from an empty holding reg.
      cpu_write(3'd1, 16'h00A5);
      cpu_read(3'd2, rd); check("primed_status", rd, 16'h0000);
      spi_frame(8'h3C, 8, mb, oe);
      check("f1_miso", 16'(mb), 16'h00A5);
      check("f1_oe_active", 16'(oe), 16'h1);
      check("f1_oe_after", 16'(MISO_oe), 16'h0);
      check("f1_rrdy", 16'(bus.dataavailable), 16'h1);
      cpu_read(3'd2, rd); check("f1_status", rd, 16'h01E4);
      cpu_read(3'd0, rd); check("f1_rxdata", rd, 16'h003C);
      check("f1_rrdy_clr", 16'(bus.dataavailable), 16'h0);
      cpu_write(3'd2, 16'h0000);
      cpu_read(3'd2, rd); check("f1_status_clr", rd, 16'h0060);

      // Overrun with ROE irq enabled; frames carry no tx data (underrun).
      cpu_write(3'd3, 16'h0008);
      cpu_read(3'd3, rd); check("ctrl_rb", rd, 16'h0008);
      spi_frame(8'h11, 8, mb, oe);
      check("tur_miso", 16'(mb), 16'h0000);
      check("irq_no_roe", 16'(bus.irq), 16'h0);
      spi_frame(8'h22, 8, mb, oe);
      check("roe_irq", 16'(bus.irq), 16'h1);
      cpu_read(3'd2, rd); check("roe_status", rd, 16'h01EC);
      cpu_read(3'd0, rd); check("roe_rxdata", rd, 16'h0022);
      cpu_write(3'd2, 16'h0000);
      check("roe_irq_clr", 16'(bus.irq), 16'h0);
      cpu_write(3'd3, 16'h0000);

      // Double tx write: second sets TOE, first byte kept.
      cpu_write(3'd1, 16'h005A);
      cpu_write(3'd1, 16'h00C3);
      cpu_read(3'd2, rd); check("toe_status", rd, 16'h0110);
      cpu_write(3'd2, 16'h0000);

      // Partial frame of 5 bits: discarded, first 5 MISO bits of 0x5A = 01011.
      spi_frame(8'hFF, 5, mb, oe);
      check("part_miso", 16'(mb), 16'h000B);
      check("part_rrdy", 16'(bus.dataavailable), 16'h0);
      cpu_read(3'd2, rd); check("part_status", rd, 16'h0060);
      spi_frame(8'h81, 8, mb, oe);
      cpu_read(3'd2, rd); check("f81_status", rd, 16'h01E4);
      cpu_read(3'd0, rd); check("f81_rxdata", rd, 16'h0081);
      cpu_write(3'd2, 16'h0000);

      // Reset mid-frame, release with SS_n still low: no frame until a fresh fall.
      cpu_write(3'd1, 16'h0096);
      @(negedge clk); SS_n = 1'b0;
      wait_clks(HALF);
      SCLK = 1'b1; wait_clks(HALF); SCLK = 1'b0; wait_clks(20);
      check("mid_oe_before", 16'(MISO_oe), 16'h1);
      reset_n = 1'b0;
      #1;
      check("mid_oe_reset", 16'(MISO_oe), 16'h0);
      wait_clks(3);
      reset_n = 1'b1;
      wait_clks(20);
      check("mid_oe_wait", 16'(MISO_oe), 16'h0);
      for (int k = 0; k < 3; k++) begin
         SCLK = 1'b1; wait_clks(HALF); SCLK = 1'b0; wait_clks(HALF);
      end
      check("mid_no_rrdy", 16'(bus.dataavailable), 16'h0);
      SS_n = 1'b1;
      wait_clks(20);
      cpu_write(3'd1, 16'h0096);
      spi_frame(8'h69, 8, mb, oe);
      check("post_miso", 16'(mb), 16'h0096);
      cpu_read(3'd0, rd); check("post_rxdata", rd, 16'h0069);
      cpu_read(3'd7, rd); check("addr7_zero", rd, 16'h0000);

`ifdef SPI_SLAVE_EOP_EN
      cpu_write(3'd6, 16'h000D);
      cpu_read(3'd6, rd); check("eopval_rb", rd, 16'h000D);
      spi_frame(8'h0D, 8, mb, oe);
      check("eop_pre", 16'(bus.endofpacket), 16'h0);
      cpu_read(3'd0, rd); check("eop_rxdata", rd, 16'h000D);
      check("eop_pin", 16'(bus.endofpacket), 16'h1);
      cpu_read(3'd2, rd); check("eop_status", rd, 16'h0364);
`else
      cpu_write(3'd6, 16'h000D);
      cpu_read(3'd6, rd); check("eopval_absent", rd, 16'h0000);
      spi_frame(8'h0D, 8, mb, oe);
      cpu_read(3'd0, rd); check("noeop_rxdata", rd, 16'h000D);
      check("noeop_pin", 16'(bus.endofpacket), 16'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
